svc_gfx_fb_mem_sched: RTL and testbench

// Shares one single-beat AXI master port between two requesters of the fade

---
 rtl/svc_gfx_fb_mem_sched.sv | 146 ++++++++++++++
 tb/tb_svc_gfx_fb_mem_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_gfx_fb_mem_sched.sv
// svc_gfx_fb_mem_sched: shares one single-beat AXI master between gfx framebuffer writes and scanout prefetch reads
//
// Purpose:
//   One transaction in flight at a time. In IDLE, an urgent read always wins.
//   When both sides are valid and neither read is urgent, the side not served
//   last wins (round-robin). Otherwise the only valid side wins. The winner's
//   address and data are captured on accept and replayed on the AXI channels.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wr_valid/wr_addr/wr_data/wr_ready gfx write request, ready pulses on accept
//   rd_valid/rd_addr/rd_urgent/rd_ready
//                                     scanout read request, urgent = FIFO low
//   rd_resp_valid/rd_resp_data/rd_resp_ready
//                                     read data returned straight from R
//   err                               sticky: non-OKAY resp or R without rlast
//   m_axi_*                           single-beat AXI4 master (ids 0, INCR, len 0)
module svc_gfx_fb_mem_sched #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH = 4,
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_ready,
  input  logic                      rd_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rd_urgent,
  output logic                      rd_ready,
  output logic                      rd_resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] rd_resp_data,
  input  logic                      rd_resp_ready,
  output logic                      err,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WA, WB, RA, RR} state_t;
  state_t state_q, state_d;
  // rr_last_q: 1 when the read side was served last; reset says write, so the first tie goes to the read
  logic rr_last_q, rr_last_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d, err_q, err_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic rd_win, wr_acc, rd_acc, b_hs, r_hs;
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};
  always_comb begin
    rd_win = rd_valid && (rd_urgent || !wr_valid || !rr_last_q);
    rd_acc = !rst && state_q == IDLE && rd_win;
    wr_acc = !rst && state_q == IDLE && wr_valid && !rd_win;
    b_hs = state_q == WB && m_axi_bvalid;
    r_hs = state_q == RR && m_axi_rvalid && rd_resp_ready;
    // AW and W retire independently; WB only once both have handshaken
    awvalid_d = wr_acc || (awvalid_q && !m_axi_awready);
    wvalid_d = wr_acc || (wvalid_q && !m_axi_wready);
    arvalid_d = rd_acc || (arvalid_q && !m_axi_arready);
    addr_d = wr_acc ? wr_addr : rd_acc ? rd_addr : addr_q;
    data_d = wr_acc ? wr_data : data_q;
    rr_last_d = rd_acc ? 1'b1 : wr_acc ? 1'b0 : rr_last_q;
    err_d = err_q || (b_hs && m_axi_bresp != 2'b00) || (r_hs && (m_axi_rresp != 2'b00 || !m_axi_rlast));
    state_d = state_q;
    case (state_q)
      IDLE: state_d = wr_acc ? WA : rd_acc ? RA : IDLE;
      WA: state_d = (!awvalid_d && !wvalid_d) ? WB : WA;
      WB: state_d = m_axi_bvalid ? IDLE : WB;
      RA: state_d = m_axi_arready ? RR : RA;
      RR: state_d = r_hs ? IDLE : RR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_last_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      rr_last_q <= rr_last_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      arvalid_q <= arvalid_d;
      err_q <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign wr_ready = wr_acc;
  assign rd_ready = rd_acc;
  assign err = err_q;
  assign rd_resp_valid = state_q == RR && m_axi_rvalid;
  assign rd_resp_data = m_axi_rdata;
  assign m_axi_rready = state_q == RR && rd_resp_ready;
  assign m_axi_bready = state_q == WB;
  assign m_axi_awid = '0;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = 8'd0;
  assign m_axi_awsize = 3'($clog2(AXI_STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata = data_q;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = 1'b1;
  assign m_axi_wvalid = wvalid_q;
  assign m_axi_arid = '0;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = 8'd0;
  assign m_axi_arsize = 3'($clog2(AXI_STRB_WIDTH));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
endmodule

// File: tb/tb_svc_gfx_fb_mem_sched.sv
// tb_svc_gfx_fb_mem_sched: directed scenarios plus randomized traffic against a transaction-level model
module tb_svc_gfx_fb_mem_sched;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic wr_valid, wr_ready, rd_valid, rd_urgent, rd_ready, rd_resp_valid, rd_resp_ready, err;
  logic [15:0] wr_addr, wr_data, rd_addr, rd_resp_data;
  logic [3:0] awid, arid, bid, rid;
  logic [15:0] awaddr, wdata, araddr, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, wstrb, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, arready, rlast, rvalid, rready;
  svc_gfx_fb_mem_sched dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_urgent(rd_urgent), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_ready(rd_resp_ready), .err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );
  int n_cmp = 0, n_fail = 0;
  // transaction-level model: one outstanding transaction and which of its phases are done
  logic m_busy = 0, m_wr = 0, m_aw = 0, m_w = 0, m_ar = 0, m_last_rd = 0, m_err = 0;
  logic [15:0] m_addr = 0, m_data = 0;
  // slave bookkeeping
  logic s_aw = 0, s_w = 0, b_pend = 0, r_pend = 0, awv_prev = 0, wv_prev = 0, arv_prev = 0;
  // stimulus knobs
  logic rand_req = 0, rand_slv = 0, err_rand = 0, hold_aw = 0, force_rrdy_en = 0, force_rrdy_val = 0, sc_urgent = 0;
  logic [1:0] sc_bresp = 0;
  int sc_wr_cnt = 0, sc_rd_cnt = 0;
  logic [15:0] sc_wr_addr = 0, sc_wr_data = 0, sc_rd_addr = 0;
  // observations
  logic wr_acc_o = 0, rd_acc_o = 0, last_wlast = 0;
  bit grant_log[$];
  int wr_pulses = 0, rd_pulses = 0, b_cnt = 0;
  logic [15:0] last_awaddr = 0, last_wdata = 0;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic check_cycle();
    int pick;
    logic e_wrdy, e_rrdy, e_awv, e_wv, e_b, e_arv, e_r;
    // 0 none, 1 write, 2 read
    if (rd_valid && rd_urgent) pick = 2;
    else if (rd_valid && wr_valid) pick = m_last_rd ? 1 : 2;
    else pick = rd_valid ? 2 : wr_valid ? 1 : 0;
    e_wrdy = !rst && !m_busy && pick == 1;
    e_rrdy = !rst && !m_busy && pick == 2;
    cmp("wr_ready", wr_ready, e_wrdy);
    cmp("rd_ready", rd_ready, e_rrdy);
    cmp("err", err, m_err);
    cmp("rd_resp_data", rd_resp_data, rdata);
    cmp("aw_consts", {awid, awlen, awsize, awburst}, {4'h0, 8'h00, 3'd1, 2'b01});
    cmp("ar_w_consts", {arid, arlen, arsize, arburst, wstrb, wlast}, {4'h0, 8'h00, 3'd1, 2'b01, 2'b11, 1'b1});
    wr_acc_o = wr_ready && wr_valid;
    rd_acc_o = rd_ready && rd_valid;
    if (wr_ready) begin wr_pulses++; grant_log.push_back(1'b0); if (sc_wr_cnt > 0) sc_wr_cnt--; end
    if (rd_ready) begin rd_pulses++; grant_log.push_back(1'b1); if (sc_rd_cnt > 0) sc_rd_cnt--; end
    if (!rst) begin
      e_awv = m_busy && m_wr && !m_aw;
      e_wv = m_busy && m_wr && !m_w;
      e_b = m_busy && m_wr && m_aw && m_w;
      e_arv = m_busy && !m_wr && !m_ar;
      e_r = m_busy && !m_wr && m_ar;
      cmp("awvalid", awvalid, e_awv);
      cmp("wvalid", wvalid, e_wv);
      cmp("bready", bready, e_b);
      cmp("arvalid", arvalid, e_arv);
      cmp("m_axi_rready", rready, e_r && rd_resp_ready);
      cmp("rd_resp_valid", rd_resp_valid, e_r && rvalid);
      if (e_awv) cmp("awaddr", awaddr, m_addr);
      if (e_wv) cmp("wdata", wdata, m_data);
      if (e_arv) cmp("araddr", araddr, m_addr);
      if (awvalid && awready) last_awaddr = awaddr;
      if (wvalid && wready) begin last_wdata = wdata; last_wlast = wlast; end
      if (e_awv && awready) m_aw = 1;
      if (e_wv && wready) m_w = 1;
      if (e_arv && arready) m_ar = 1;
      if (e_b && bvalid) begin m_err = m_err | (bresp != 2'b00); m_busy = 0; b_cnt++; end
      if (e_r && rvalid && rd_resp_ready) begin m_err = m_err | (rresp != 2'b00) | !rlast; m_busy = 0; end
      if (e_wrdy) begin m_busy = 1; m_wr = 1; m_aw = 0; m_w = 0; m_addr = wr_addr; m_data = wr_data; m_last_rd = 0; end
      if (e_rrdy) begin m_busy = 1; m_wr = 0; m_ar = 0; m_addr = rd_addr; m_last_rd = 1; end
      if (awvalid && awready) s_aw = 1;
      if (wvalid && wready) s_w = 1;
      if (bvalid && bready) begin s_aw = 0; s_w = 0; b_pend = 0; end
      else if (s_aw && s_w) b_pend = 1;
      if (arvalid && arready) r_pend = 1;
      if (rvalid && rready) r_pend = 0;
    end else begin
      m_busy = 0; m_last_rd = 0; m_err = 0;
      s_aw = 0; s_w = 0; b_pend = 0; r_pend = 0;
    end
    awv_prev = awvalid && !awready;
    wv_prev = wvalid && !wready;
    arv_prev = arvalid && !arready;
  endtask
  task automatic drive();
    awready = hold_aw ? 1'b0 : rand_slv ? 1'($urandom % 2) : awv_prev;
    wready = hold_aw ? 1'b0 : rand_slv ? 1'($urandom % 2) : wv_prev;
    arready = rand_slv ? 1'($urandom % 2) : arv_prev;
    if (!b_pend) bvalid = 1'b0;
    else if (!bvalid && (!rand_slv || $urandom % 2 == 0)) begin
      bvalid = 1'b1;
      bresp = rand_slv ? ((err_rand && $urandom % 6 == 0) ? 2'b10 : 2'b00) : sc_bresp;
    end
    if (!r_pend) rvalid = 1'b0;
    else if (!rvalid && (!rand_slv || $urandom % 2 == 0)) begin
      rvalid = 1'b1;
      rdata = 16'($urandom);
      rresp = (rand_slv && err_rand && $urandom % 6 == 0) ? 2'b10 : 2'b00;
      rlast = !(rand_slv && err_rand && $urandom % 8 == 0);
    end
    bid = 4'($urandom);
    rid = 4'($urandom);
    rd_resp_ready = force_rrdy_en ? force_rrdy_val : ($urandom % 4 != 0);
    if (rand_req) begin
      if (!wr_valid || wr_acc_o) begin wr_valid = ($urandom % 3 == 0); wr_addr = 16'($urandom); wr_data = 16'($urandom); end
      if (!rd_valid || rd_acc_o) begin rd_valid = ($urandom % 3 == 0); rd_addr = 16'($urandom); end
      rd_urgent = ($urandom % 6 == 0);
    end else begin
      wr_valid = sc_wr_cnt != 0; wr_addr = sc_wr_addr; wr_data = sc_wr_data;
      rd_valid = sc_rd_cnt != 0; rd_addr = sc_rd_addr; rd_urgent = sc_urgent;
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      drive();
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while ((sc_wr_cnt != 0 || sc_rd_cnt != 0 || m_busy) && n < lim) begin cyc(1); n++; end
    if (n >= lim) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, lim);
    end
    cyc(1);
  endtask
  function automatic logic [31:0] log_bits();
    logic [31:0] v = 0;
    foreach (grant_log[i]) v = {v[30:0], grant_log[i]};
    return v;
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, b0;
    logic [15:0] d0;
    wr_valid = 0; wr_addr = 0; wr_data = 0; rd_valid = 0; rd_addr = 0; rd_urgent = 0; rd_resp_ready = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 1; rid = 0;
    rst = 1;
    cyc(3);
    cmp("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rd_resp_valid}, 6'b0);
    cmp("rst_readies_err", {wr_ready, rd_ready, err}, 3'b0);
    rst = 0;
    cyc(2);
    // single write, slave ready one cycle after valid
    sc_wr_addr = 16'h0010; sc_wr_data = 16'hA5F0; wr_pulses = 0; rd_pulses = 0; b0 = b_cnt;
    sc_wr_cnt = 1;
    wait_idle("t1_idle", 40);
    cmp("t1_wr_pulses", wr_pulses, 1);
    cmp("t1_rd_pulses", rd_pulses, 0);
    cmp("t1_awaddr", last_awaddr, 16'h0010);
    cmp("t1_wdata", last_wdata, 16'hA5F0);
    cmp("t1_wlast", last_wlast, 1);
    cmp("t1_b_count", b_cnt - b0, 1);
    // both held, no urgency: alternate starting with the read
    grant_log.delete();
    sc_rd_addr = 16'h0200; sc_wr_addr = 16'h0300; sc_wr_data = 16'h1234;
    sc_wr_cnt = 2; sc_rd_cnt = 2;
    wait_idle("t2_idle", 80);
    cmp("t2_grant_count", grant_log.size(), 4);
    cmp("t2_grants", log_bits(), 32'b1010);
    // urgent reads starve the write until urgency drops
    grant_log.delete();
    sc_urgent = 1; sc_rd_cnt = 6; sc_wr_cnt = 1;
    n = 0;
    while (grant_log.size() < 4 && n < 60) begin cyc(1); n++; end
    cmp("t3_four_reads_seen", grant_log.size() >= 4, 1);
    sc_urgent = 0;
    wait_idle("t3_idle", 100);
    cmp("t3_grant_count", grant_log.size(), 7);
    cmp("t3_grants", log_bits(), 32'b1111011);
    // read response back-pressured for 5 cycles
    force_rrdy_en = 1; force_rrdy_val = 0; sc_rd_addr = 16'h0400; sc_rd_cnt = 1;
    n = 0;
    while (!rd_resp_valid && n < 30) begin cyc(1); n++; end
    cmp("t4_resp_seen", rd_resp_valid, 1);
    d0 = rd_resp_data;
    for (int i = 0; i < 5; i++) begin
      cmp("t4_hold_valid", rd_resp_valid, 1);
      cmp("t4_hold_rready", rready, 0);
      cmp("t4_hold_data", rd_resp_data, d0);
      cyc(1);
    end
    force_rrdy_val = 1;
    cyc(1);
    cmp("t4_handshake", {rd_resp_valid, rready}, 2'b11);
    cyc(1);
    cmp("t4_back_idle", {rd_resp_valid, rready, arvalid, awvalid}, 4'b0);
    force_rrdy_en = 0;
    cyc(2);
    // SLVERR on B sets sticky err
    sc_bresp = 2'b10; sc_wr_cnt = 1;
    wait_idle("t5_idle", 40);
    cmp("t5_err_set", err, 1);
    sc_bresp = 2'b00; sc_wr_cnt = 1; sc_rd_cnt = 1;
    wait_idle("t5_idle2", 60);
    cmp("t5_err_sticky", err, 1);
    // reset during WA with AW/W stalled
    hold_aw = 1; sc_wr_addr = 16'h0050; sc_wr_data = 16'h00FF; sc_wr_cnt = 1;
    n = 0;
    while (!awvalid && n < 20) begin cyc(1); n++; end
    cmp("t6_in_wa", {awvalid, wvalid}, 2'b11);
    rst = 1;
    cyc(1);
    cmp("t6_valids_dropped", {awvalid, wvalid, bready}, 3'b0);
    cmp("t6_err_cleared", err, 0);
    rst = 0; hold_aw = 0; b0 = b_cnt;
    sc_wr_cnt = 1;
    wait_idle("t6_idle", 40);
    cmp("t6_fresh_write", b_cnt - b0, 1);
    cmp("t6_awaddr", last_awaddr, 16'h0050);
    // randomized traffic with occasional resets, error responses in the second half
    rand_req = 1; rand_slv = 1;
    for (int i = 0; i < 6000; i++) begin
      err_rand = (i >= 3000);
      if ($urandom % 300 == 0) begin rst = 1; cyc(1); rst = 0; end
      else cyc(1);
    end
    rand_req = 0;
    wait_idle("final_idle", 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
